// File: rtl/mc_result_buffer_if.sv
// Result-buffer handshake bundle.
// Issue credits, completions and CDB request/grant.
interface mc_result_buffer_if #(
  parameter int SIZE  = 32,
  parameter int TAG_W = 5
);
  logic             issue_fire;
  logic             issue_stall;
  logic             in_valid;
  logic [SIZE-1:0]  in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             cdb_req;
  logic [SIZE-1:0]  cdb_instr;
  logic [TAG_W-1:0] cdb_tag;
  logic             cdb_grant;

  modport master (
    output issue_fire, in_valid, in_instr,
    output in_tag, cdb_grant,
    input  issue_stall, cdb_req, cdb_instr,
    input  cdb_tag
  );

  modport slave (
    input  issue_fire, in_valid, in_instr,
    input  in_tag, cdb_grant,
    output issue_stall, cdb_req, cdb_instr,
    output cdb_tag
  );
endinterface

// File: rtl/mc_result_buffer.sv
// Multi-cycle unit result FIFO with issue credits.
// Holds finished results until the CDB grants them.
module mc_result_buffer #(
  parameter  int SIZE  = 32,
  parameter  int TAG_W = 5,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  mc_result_buffer_if.slave bus,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] PONE_C = AW'(1);

  typedef struct packed {
    logic [SIZE-1:0]  instr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] inflight;
  logic [CW:0]   load;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic under;
  logic over;

  assign empty = (count == '0);
  assign full  = (count == FULL_C);
  assign pop   = !empty && bus.cdb_grant;
  assign push  = bus.in_valid && (!full || pop);
  assign drop  = bus.in_valid && full && !pop;
  assign under = bus.in_valid && !bus.issue_fire
              && (inflight == '0);
  assign over  = bus.issue_fire && bus.issue_stall;

  assign load = {1'b0, count} + {1'b0, inflight};

  assign bus.issue_stall = (load >= {1'b0, FULL_C});
  assign bus.cdb_req     = !empty;
  assign bus.cdb_instr   = empty ? '0 : mem[rd_ptr].instr;
  assign bus.cdb_tag     = empty ? '0 : mem[rd_ptr].tag;

  // Storage is never cleared; empty masks it on the outputs.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= '{instr: bus.in_instr, tag: bus.in_tag};
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PONE_C;
      if (pop)  rd_ptr <= rd_ptr + PONE_C;
    end
  end

  // Occupancy: push and pop together cancel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: count <= count + ONE_C;
        pop && !push: count <= count - ONE_C;
        default:      count <= count;
      endcase
    end
  end

  // Outstanding credits, saturating at both ends.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      unique case (1'b1)
        bus.issue_fire && !bus.in_valid:
          if (inflight != FULL_C)
            inflight <= inflight + ONE_C;
        bus.in_valid && !bus.issue_fire:
          if (inflight != '0)
            inflight <= inflight - ONE_C;
        default:
          inflight <= inflight;
      endcase
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (drop || under || over)
      err <= 1'b1;
  end

endmodule

// File: tb/tb_mc_result_buffer.sv
// Testbench for mc_result_buffer.
// Queue reference model with a decoupled pop monitor.
module tb_mc_result_buffer;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count;
  logic       err;

  mc_result_buffer_if #(.SIZE(32), .TAG_W(5)) bus ();

  mc_result_buffer #(
    .SIZE(32), .TAG_W(5), .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .count(count),
    .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [36:0] mq[$];
  logic [36:0] exp_q[$];
  int          m_inflight = 0;
  bit          m_err = 1'b0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    chk("count", 64'(count), 64'(n));
    chk("cdb_req", 64'(bus.cdb_req), 64'(n != 0));
    chk("issue_stall", 64'(bus.issue_stall),
        64'((n + m_inflight) >= DEPTH));
    chk("err", 64'(err), 64'(m_err));
    if (n == 0)
      chk("empty_head", {bus.cdb_instr, bus.cdb_tag}, 64'd0);
    else
      chk("head", {bus.cdb_instr, bus.cdb_tag}, 64'(mq[0]));
  endtask

  // Apply one cycle of inputs at the negedge, advance the model.
  task automatic step(bit f, bit v, logic [31:0] ins,
                      logic [4:0] tg, bit g);
    int  n;
    bit  st;
    bit  pp;
    bit  fl;
    check_state();
    bus.issue_fire = f;
    bus.in_valid   = v;
    bus.in_instr   = ins;
    bus.in_tag     = tg;
    bus.cdb_grant  = g;
    n  = mq.size();
    st = (n + m_inflight) >= DEPTH;
    pp = (n > 0) && g;
    fl = (n == DEPTH);
    if (f && st) m_err = 1'b1;
    if (pp) void'(mq.pop_front());
    if (v) begin
      if (!fl || pp) begin
        mq.push_back({ins, tg});
        exp_q.push_back({ins, tg});
      end else begin
        m_err = 1'b1;
      end
    end
    if (f && !v) begin
      if (m_inflight < DEPTH) m_inflight++;
    end else if (v && !f) begin
      if (m_inflight == 0) m_err = 1'b1;
      else m_inflight--;
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.issue_fire = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_tag     = '0;
    bus.cdb_grant  = 1'b0;
  endtask

  // Called at a negedge; checks the asynchronous clear.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req", 64'(bus.cdb_req), 64'd0);
    chk("rst_stall", 64'(bus.issue_stall), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_head", {bus.cdb_instr, bus.cdb_tag}, 64'd0);
    mq.delete();
    exp_q.delete();
    m_inflight = 0;
    m_err = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Scoreboard monitor: compares every granted head entry.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (reset === 1'b1 && bus.cdb_req === 1'b1 &&
          bus.cdb_grant === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cdb_pop actual=%0h required=none",
                   {bus.cdb_instr, bus.cdb_tag});
        end else begin
          e = exp_q.pop_front();
          chk("cdb_pop", {bus.cdb_instr, bus.cdb_tag}, 64'(e));
        end
      end
    end
  end

  initial begin
    bit f;
    bit v;
    idle_inputs();
    @(negedge clock);
    do_reset();

    // Single instruction round trip.
    step(1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD0001, 5'd3, 1'b0);
    check_state();
    chk("dead_req", 64'(bus.cdb_req), 64'd1);
    chk("dead_instr", 64'(bus.cdb_instr), 64'hDEAD0001);
    chk("dead_tag", 64'(bus.cdb_tag), 64'd3);
    chk("dead_count", 64'(count), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check_state();
    chk("dead_pop_count", 64'(count), 64'd0);
    chk("dead_pop_instr", 64'(bus.cdb_instr), 64'd0);

    // Credits exhausted, then fill the FIFO.
    repeat (8) step(1'b1, 1'b0, '0, '0, 1'b0);
    chk("credit_stall", 64'(bus.issue_stall), 64'd1);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 32'hA0000000 + i, 5'(i), 1'b0);
    chk("full_count", 64'(count), 64'd8);
    chk("full_stall", 64'(bus.issue_stall), 64'd1);
    chk("full_err", 64'(err), 64'd0);

    // Push with pop while full, then a dropped push.
    step(1'b0, 1'b1, 32'hB0000001, 5'd20, 1'b1);
    chk("full_pp_count", 64'(count), 64'd8);
    step(1'b0, 1'b1, 32'hB0000002, 5'd21, 1'b0);
    chk("drop_count", 64'(count), 64'd8);
    chk("drop_err", 64'(err), 64'd1);
    repeat (8) step(1'b0, 1'b0, '0, '0, 1'b1);
    check_state();

    // Push/pop pairs across the pointer wrap.
    do_reset();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 32'hC0000000 + i, 5'(i), 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check_state();
    chk("wrap_err", 64'(err), 64'd0);
    chk("wrap_left", 64'(exp_q.size()), 64'd0);

    // Completion without credit.
    do_reset();
    step(1'b0, 1'b1, 32'h11111111, 5'd1, 1'b0);
    check_state();
    chk("under_err", 64'(err), 64'd1);
    chk("under_stall", 64'(bus.issue_stall), 64'd0);

    // Issue while stalled.
    do_reset();
    repeat (8) step(1'b1, 1'b0, '0, '0, 1'b0);
    chk("pre_over_err", 64'(err), 64'd0);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    check_state();
    chk("over_err", 64'(err), 64'd1);

    // Randomized traffic, mostly protocol-respecting.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      f = (((mq.size() + m_inflight) < DEPTH) &&
           ($urandom_range(1, 0) == 1)) ||
          ($urandom_range(63, 0) == 0);
      v = ((m_inflight > 0) && ($urandom_range(1, 0) == 1)) ||
          ($urandom_range(63, 0) == 0);
      step(f, v, $urandom, 5'($urandom_range(31, 0)),
           $urandom_range(1, 0) == 1);
    end
    repeat (10) step(1'b0, 1'b0, '0, '0, 1'b1);
    check_state();

    // Reset in the middle of traffic.
    do_reset();
    repeat (7) step(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 32'hE0000000 + i, 5'(i), 1'b0);
    check_state();
    chk("mid_count", 64'(count), 64'd5);
    do_reset();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hF0000001, 5'd9, 1'b0);
    check_state();
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
